morse_sequencer: RTL and testbench
==================================

# morse_sequencer

Element sequencer between the PS/2 keycode-to-Morse lookup and the tone generator. Accepts one Morse character per valid/ready handshake as a packed dit/dah pattern and drives the tone generator's `dit`/`dah` inputs with standard Morse timing: dit 1 unit, dah 3 units, inter-element gap 1 unit, inter-character gap 3 units, word space. Unit length is a parameter in clock cycles, so keying speed (WPM) is fixed at elaboration.

## Interface
- `UNIT_CYCLES`, default 3_000_000: clock cycles per Morse unit (60 ms at 50 MHz, 20 WPM); minimum 2.
- `MAX_LEN`, default 5: maximum elements per character.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, one clock; reset is synchronous and active-low.
- `code_valid`  in  1  character available.
- `code_len`  in  3  element count; 0 = word space; values above `MAX_LEN` treated as `MAX_LEN`.
- `code_bits`  in  `MAX_LEN`  pattern, LSB sent first; 1 = dah, 0 = dit; bits at or above `code_len` ignored.
- `code_ready`  out  1  high only in IDLE.
- `abort`  in  1  cancel the current character immediately.
- `dit`  out  1  to tone generator, high while a dit sounds.
- `dah`  out  1  to tone generator, high while a dah sounds.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ELEM, GAP_ELEM, GAP_CHAR, GAP_WORD.
- IDLE: `code_ready`=1. On `code_valid && code_ready`, latch pattern and clamped length into a shift register and element counter. If len=0 go to GAP_WORD, otherwise go to ELEM.
- ELEM: `dah`=current bit, `dit`=~current bit, held for 3 or 1 units. Then decrement the remaining count and shift. If any elements remain go to GAP_ELEM, otherwise go to GAP_CHAR.
- GAP_ELEM: 1 unit silent, then ELEM.
- GAP_CHAR: 3 units silent, then IDLE.
- GAP_WORD: 4 units silent, then IDLE. A word space following a character therefore totals 7 units.
- Unit timer: cycle counter, width `$clog2(UNIT_CYCLES)`. Wraps at `UNIT_CYCLES-1` and emits a 1-cycle unit tick. Cleared on every state entry so each state lasts an exact multiple of `UNIT_CYCLES`.
- Unit counter: 3 bits, counts ticks within a state; max 4.
- `dit` and `dah` are never high at the same time. Both are 0 in all gap states and in IDLE.
- `abort` in any state: next cycle is IDLE, `dit`=`dah`=0, counters cleared, latched pattern discarded. Abort has priority over accept in IDLE; a character presented with `abort` high is not accepted.
- Inputs are sampled only at accept. Changes to `code_bits`/`code_len` after accept have no effect.

## Timing
- Reset values: state IDLE, `code_ready`=1, `busy`=0, `dit`=0, `dah`=0, all counters 0.
- Reset asserted mid-character has the same effect as abort. Outputs are low on the first edge with `rst_n`=0.
- Accept at edge N: `dit`/`dah` valid from cycle N+1 (1-cycle latency). `busy` rises at N+1 and `code_ready` falls at N+1.
- Dit high for exactly `UNIT_CYCLES` cycles; dah for exactly 3×`UNIT_CYCLES`.
- Character of k elements with d dahs occupies (2k+2d+2)×`UNIT_CYCLES` cycles from N+1. `code_ready` is high again at the cycle after that.
- Back-to-back: with `code_valid` held high, the next accept occurs on the first IDLE cycle. IDLE lasts 1 cycle between characters.
- All outputs are registered.

## Structure
- Shared package `morse_pkg`:
  - state encoding;
  - `DIT_UNITS`=1, `DAH_UNITS`=3, `ELEM_GAP_UNITS`=1, `CHAR_GAP_UNITS`=3, `WORD_EXTRA_UNITS`=4;
  - `MAX_LEN`.
  The keycode lookup also uses this package.
- One sub-module, `unit_timer`: the parameterised prescaler with synchronous clear input and tick output. It can be reused to derive tone timing.
- The FSM, shift register and element/unit counters live in `morse_sequencer`.

## Test plan
All scenarios use `UNIT_CYCLES`=4.
- 'A': len=2, bits=0b10, accepted at cycle 0 -> `dit` high cycles 1–4, low 5–8, `dah` high 9–20, low 21–32, `code_ready`=1 at 33.
- Word space: len=0 -> `busy` high cycles 1–16, `dit`=`dah`=0 throughout, `code_ready` at 17.
- Back-to-back: 'E' (len=1, bits=0) then 'T' (len=1, bits=1), `code_valid` held high -> `dit` 1–4, IDLE at 17, second accept at 17, `dah` 18–29, ready at 42.
- Abort: 'O' (len=3, bits=0b111), `abort` pulsed at cycle 10 -> `dah`=0 and `busy`=0 from cycle 11. A new character with `code_valid` high at 11 is accepted at 11.
- Reset mid-dah: `rst_n`=0 at cycle 6 during 'T' -> all outputs at reset values from cycle 7. After release, `code_ready`=1.
- Length clamp: len=7, bits=0b00000 -> exactly 5 dits of 4 cycles each, with 4-cycle gaps between them, then `code_ready` at 49.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: sequencer state encoding, element/gap lengths in units,
// and the maximum character length. The keycode lookup imports these as well.
package morse_pkg;

    localparam int MAX_LEN = 5;

    localparam int DIT_UNITS        = 1;
    localparam int DAH_UNITS        = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int CHAR_GAP_UNITS   = 3;
    localparam int WORD_EXTRA_UNITS = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ELEM     = 3'd1;
    localparam logic [2:0] S_GAP_ELEM = 3'd2;
    localparam logic [2:0] S_GAP_CHAR = 3'd3;
    localparam logic [2:0] S_GAP_WORD = 3'd4;

endpackage

// File: rtl/morse_sequencer_unit_timer.sv
// Prescaler: counts clock cycles and pulses o_tick on the last cycle of each unit.
// i_clear restarts the unit so the next cycle is cycle 0 of a fresh unit.
module unit_timer #(
    parameter int UNIT_CYCLES = 3_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              W    = $clog2(UNIT_CYCLES);
    localparam logic [W-1:0]    LAST = W'(UNIT_CYCLES - 1);

    logic [W-1:0] r_count;

    // NOTE: reset is sampled on the clock edge and state uses <= so every register updates together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    // Not gated by i_clear: the clear is itself derived from this tick in the sequencer.
    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/morse_sequencer.sv
// Morse element sequencer: takes one packed dit/dah character per handshake and
// drives registered dit/dah outputs with standard unit timing and gaps.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 3_000_000,
    parameter int MAX_LEN     = morse_pkg::MAX_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               code_valid,
    input  logic [2:0]         code_len,
    input  logic [MAX_LEN-1:0] code_bits,
    output logic               code_ready,
    input  logic               abort,
    output logic               dit,
    output logic               dah,
    output logic               busy
);

    import morse_pkg::*;

    logic [2:0]         r_state;
    logic [MAX_LEN-1:0] r_shift;
    logic [2:0]         r_remain;
    logic [2:0]         r_units;
    logic               r_dit;
    logic               r_dah;
    logic               r_ready;
    logic               r_busy;

    logic [2:0]         w_next_state;
    logic [MAX_LEN-1:0] w_next_shift;
    logic [2:0]         w_next_remain;
    logic [2:0]         w_need;
    logic [2:0]         w_len;
    logic               w_tick;
    logic               w_done;
    logic               w_leave;

    assign w_len   = (code_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : code_len;
    assign w_leave = (w_next_state != r_state) || (r_state == S_IDLE);

    unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_unit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_leave),
        .o_tick (w_tick)
    );

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_need = 3'd1;
        case (r_state)
            S_ELEM:     w_need = r_shift[0] ? 3'(DAH_UNITS) : 3'(DIT_UNITS);
            S_GAP_ELEM: w_need = 3'(ELEM_GAP_UNITS);
            S_GAP_CHAR: w_need = 3'(CHAR_GAP_UNITS);
            S_GAP_WORD: w_need = 3'(WORD_EXTRA_UNITS);
            default:    w_need = 3'd1;
        endcase
    end

    assign w_done = w_tick && (r_units == (w_need - 3'd1));

    always_comb begin
        w_next_state  = r_state;
        w_next_shift  = r_shift;
        w_next_remain = r_remain;
        if (abort) begin
            w_next_state  = S_IDLE;
            w_next_shift  = '0;
            w_next_remain = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (code_valid) begin
                        w_next_shift  = code_bits;
                        w_next_remain = w_len;
                        w_next_state  = (w_len == 3'd0) ? S_GAP_WORD : S_ELEM;
                    end
                end
                S_ELEM: begin
                    if (w_done) begin
                        w_next_shift  = r_shift >> 1;
                        w_next_remain = r_remain - 3'd1;
                        w_next_state  = (r_remain > 3'd1) ? S_GAP_ELEM : S_GAP_CHAR;
                    end
                end
                S_GAP_ELEM: if (w_done) w_next_state = S_ELEM;
                S_GAP_CHAR: if (w_done) w_next_state = S_IDLE;
                S_GAP_WORD: if (w_done) w_next_state = S_IDLE;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_remain <= '0;
            r_units  <= '0;
            r_dit    <= 1'b0;
            r_dah    <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_shift  <= w_next_shift;
            r_remain <= w_next_remain;
            if (w_leave) begin
                r_units <= '0;
            end else if (w_tick) begin
                r_units <= r_units + 3'd1;
            end
            r_dit    <= (w_next_state == S_ELEM) && !w_next_shift[0];
            r_dah    <= (w_next_state == S_ELEM) &&  w_next_shift[0];
            r_ready  <= (w_next_state == S_IDLE);
            r_busy   <= (w_next_state != S_IDLE);
        end
    end

    assign code_ready = r_ready;
    assign busy       = r_busy;
    assign dit        = r_dit;
    assign dah        = r_dah;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with UNIT_CYCLES=4: a table of characters with
// hand-computed lengths, plus back-to-back, abort and mid-character reset sequences.
module tb_morse_sequencer;

    localparam int UNIT = 4;

    typedef struct {
        string      name;
        logic [2:0] len;
        logic [4:0] bits;
        int         total;   // cycles from accept+1 until code_ready returns, hand-computed
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [2:0] code_len;
    logic [4:0] code_bits;
    logic       code_ready;
    logic       abort;
    logic       dit;
    logic       dah;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_wave [0:255];
    vec_t       vecs [0:8];

    morse_sequencer #(
        .UNIT_CYCLES(UNIT),
        .MAX_LEN    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_valid(code_valid),
        .code_len  (code_len),
        .code_bits (code_bits),
        .code_ready(code_ready),
        .abort     (abort),
        .dit       (dit),
        .dah       (dah),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s {dah,dit,busy,ready} got=%b exp=%b", name, got, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {dah, dit, busy, code_ready};
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!code_ready && n < budget) begin
            step();
            n++;
        end
        check({name, " idle_wait"}, {3'b000, code_ready}, 4'b0001);
    endtask

    // Expected {dah,dit} per cycle from the Morse timing rules.
    task automatic build_wave(input vec_t v, output int n);
        int k;
        int u;
        n = 0;
        k = (v.len > 3'd5) ? 5 : int'(v.len);
        if (k == 0) begin
            for (int j = 0; j < 4 * UNIT; j++) begin exp_wave[n] = 2'b00; n++; end
        end else begin
            for (int i = 0; i < k; i++) begin
                u = v.bits[i] ? 3 : 1;
                for (int j = 0; j < u * UNIT; j++) begin
                    exp_wave[n] = {v.bits[i], ~v.bits[i]};
                    n++;
                end
                if (i < k - 1) begin
                    for (int j = 0; j < UNIT; j++) begin exp_wave[n] = 2'b00; n++; end
                end
            end
            for (int j = 0; j < 3 * UNIT; j++) begin exp_wave[n] = 2'b00; n++; end
        end
    endtask

    task automatic run_vector(input vec_t v);
        int          n;
        logic [3:0]  exp;
        build_wave(v, n);
        wait_idle(v.name, 200);
        code_valid = 1'b1;
        code_len   = v.len;
        code_bits  = v.bits;
        step();
        // Scrambled inputs after accept must have no effect.
        code_valid = 1'b0;
        code_len   = 3'd1;
        code_bits  = ~v.bits;
        for (int c = 1; c <= v.total + 1; c++) begin
            if (c <= v.total) begin
                exp = (c - 1 < n) ? {exp_wave[c-1], 2'b10} : 4'b0010;
            end else begin
                exp = 4'b0001;
            end
            check($sformatf("%s c%0d", v.name, c), outs(), exp);
            if (c <= v.total) step();
        end
    endtask

    initial begin
        logic [3:0] exp;

        vecs[0] = '{name: "A",      len: 3'd2, bits: 5'b00010, total: 32};
        vecs[1] = '{name: "E",      len: 3'd1, bits: 5'b00000, total: 16};
        vecs[2] = '{name: "T",      len: 3'd1, bits: 5'b00001, total: 24};
        vecs[3] = '{name: "WORD",   len: 3'd0, bits: 5'b10101, total: 16};
        vecs[4] = '{name: "N_HIGH", len: 3'd2, bits: 5'b11101, total: 32};
        vecs[5] = '{name: "CLAMP7", len: 3'd7, bits: 5'b00000, total: 48};
        vecs[6] = '{name: "O",      len: 3'd3, bits: 5'b00111, total: 56};
        vecs[7] = '{name: "MIX5",   len: 3'd5, bits: 5'b10110, total: 72};
        vecs[8] = '{name: "CLAMP6", len: 3'd6, bits: 5'b11111, total: 88};

        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_len   = 3'd0;
        code_bits  = 5'd0;
        abort      = 1'b0;
        step();
        step();
        check("reset_state", outs(), 4'b0001);
        rst_n = 1'b1;
        step();
        check("after_reset", outs(), 4'b0001);

        // Abort has priority over accept in IDLE.
        code_valid = 1'b1;
        code_len   = 3'd1;
        code_bits  = 5'b00001;
        abort      = 1'b1;
        step();
        check("abort_prio", outs(), 4'b0001);
        code_valid = 1'b0;
        abort      = 1'b0;
        step();
        check("abort_prio_hold", outs(), 4'b0001);

        for (int i = 0; i < 9; i++) begin
            run_vector(vecs[i]);
        end

        // Back-to-back E then T with code_valid held high.
        wait_idle("b2b", 200);
        code_valid = 1'b1;
        code_len   = 3'd1;
        code_bits  = 5'b00000;
        step();
        code_bits  = 5'b00001;
        for (int c = 1; c <= 42; c++) begin
            if (c <= 4)       exp = 4'b0110;
            else if (c <= 16) exp = 4'b0010;
            else if (c == 17) exp = 4'b0001;
            else if (c <= 29) exp = 4'b1010;
            else if (c <= 41) exp = 4'b0010;
            else              exp = 4'b0001;
            check($sformatf("b2b c%0d", c), outs(), exp);
            if (c == 18) code_valid = 1'b0;
            if (c < 42) step();
        end

        // Abort during the first dah of 'O', then immediate accept of 'E'.
        wait_idle("abort", 200);
        code_valid = 1'b1;
        code_len   = 3'd3;
        code_bits  = 5'b00111;
        step();
        code_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("abort_pre c%0d", c), outs(), 4'b1010);
            if (c == 10) abort = 1'b1;
            step();
        end
        check("abort c11", outs(), 4'b0001);
        abort      = 1'b0;
        code_valid = 1'b1;
        code_len   = 3'd1;
        code_bits  = 5'b00000;
        step();
        check("abort_accept c12", outs(), 4'b0110);
        code_valid = 1'b0;
        wait_idle("abort_after", 200);

        // Reset asserted mid-dah of 'T'.
        code_valid = 1'b1;
        code_len   = 3'd1;
        code_bits  = 5'b00001;
        step();
        code_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("rst_pre c%0d", c), outs(), 4'b1010);
            if (c == 6) rst_n = 1'b0;
            step();
        end
        check("rst c7", outs(), 4'b0001);
        rst_n = 1'b1;
        step();
        check("rst_release", outs(), 4'b0001);
        step();
        check("rst_idle", outs(), 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
